bid_accumulator10: RTL

//  Upstream feeder for the 10-way argmax stage. Consumes a stream of (class, increment) beats,

---
 rtl/bid_accumulator10_pkg.sv | 10 +
 rtl/bid_accumulator10_if.sv | 28 ++
 rtl/bid_accumulator10_sat_add.sv | 16 +
 rtl/bid_accumulator10.sv | 103 ++++++++++
 4 files changed

// File: rtl/bid_accumulator10_pkg.sv
// Shared constants and types for the 10-class bid accumulator.
package bid_pkg;
  localparam int N_CLASS = 10;
  localparam int CLS_W   = 4;
  localparam int BID_W   = 16;
  localparam int INC_W   = 8;

  typedef logic [BID_W-1:0] bid_t;
  typedef enum logic {ACCUM, PEND} acc_state_e;
endpackage

// File: rtl/bid_accumulator10_if.sv
// Beat input stream plus completed-bid-vector output handshake.
interface bid_accumulator10_if #(
  parameter int bW   = 16,
  parameter int IN_W = 8
);
  import bid_pkg::*;

  logic                            in_valid;
  logic                            in_ready;
  logic [CLS_W-1:0]                in_class;
  logic [IN_W-1:0]                 in_inc;
  logic                            in_last;
  logic [N_CLASS-1:0][bW-1:0]      bids;
  logic                            bids_valid;
  logic                            bids_ready;
  logic                            bids_sat;
  logic                            err_class;

  modport master (
    output in_valid, in_class, in_inc, in_last, bids_ready,
    input  in_ready, bids, bids_valid, bids_sat, err_class
  );

  modport slave (
    input  in_valid, in_class, in_inc, in_last, bids_ready,
    output in_ready, bids, bids_valid, bids_sat, err_class
  );
endinterface

// File: rtl/bid_accumulator10_sat_add.sv
// Saturating add of a zero-extended increment; combinational, no backpressure.
module sat_add #(
  parameter int bW   = 16,
  parameter int IN_W = 8
) (
  input  logic [bW-1:0]   a,
  input  logic [IN_W-1:0] b,
  output logic [bW-1:0]   sum,
  output logic            ovf
);
  logic [bW:0] wide;

  assign wide = {1'b0, a} + {{(bW + 1 - IN_W){1'b0}}, b};
  assign ovf  = wide[bW];
  assign sum  = ovf ? '1 : wide[bW-1:0];
endmodule

// File: rtl/bid_accumulator10.sv
// Per-class saturating bid accumulator; frame out 1 cycle after last beat.
// Second completed frame parks in the accumulator (in_ready=0) until the output bank frees.
module bid_accumulator10
  import bid_pkg::*;
#(
  parameter int bW   = BID_W,
  parameter int IN_W = INC_W
) (
  input logic                 clk,
  input logic                 rst_n,
  bid_accumulator10_if.slave  bus
);
  acc_state_e                 state, state_next;
  logic [N_CLASS-1:0][bW-1:0] acc, acc_upd, bids;
  logic                       frame_sat, sat_upd;
  logic                       bids_valid, bids_sat, err_class;
  logic                       accept, legal, consume, out_free;
  logic                       load_live, load_pend;
  logic [bW-1:0]              acc_sel, sum;
  logic                       ovf;

  assign legal    = bus.in_class < CLS_W'(N_CLASS);
  assign accept   = bus.in_valid & bus.in_ready;
  assign consume  = bids_valid & bus.bids_ready;
  assign out_free = ~bids_valid | bus.bids_ready;
  assign acc_sel  = legal ? acc[bus.in_class] : '0;

  sat_add #(.bW(bW), .IN_W(IN_W)) u_sat_add (
    .a   (acc_sel),
    .b   (bus.in_inc),
    .sum (sum),
    .ovf (ovf)
  );

  // Accumulator view with the current beat folded in; illegal classes leave it untouched.
  always_comb begin
    acc_upd = acc;
    sat_upd = frame_sat;
    if (accept && legal) begin
      acc_upd[bus.in_class] = sum;
      sat_upd               = frame_sat | ovf;
    end
  end

  always_comb begin
    state_next = state;
    load_live  = 1'b0;
    load_pend  = 1'b0;
    case (state)
      ACCUM: begin
        if (accept && bus.in_last) begin
          if (out_free) load_live  = 1'b1;
          else          state_next = PEND;
        end
      end
      PEND: begin
        if (consume) begin
          load_pend  = 1'b1;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      frame_sat  <= 1'b0;
      bids       <= '0;
      bids_valid <= 1'b0;
      bids_sat   <= 1'b0;
      err_class  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && !legal) err_class <= 1'b1;
      if (load_live) begin
        bids       <= acc_upd;
        bids_sat   <= sat_upd;
        acc        <= '0;
        frame_sat  <= 1'b0;
        bids_valid <= 1'b1;
      end else if (load_pend) begin
        bids       <= acc;
        bids_sat   <= frame_sat;
        acc        <= '0;
        frame_sat  <= 1'b0;
        bids_valid <= 1'b1;
      end else begin
        if (consume) bids_valid <= 1'b0;
        acc       <= acc_upd;
        frame_sat <= sat_upd;
      end
    end
  end

  assign bus.in_ready   = (state == ACCUM);
  assign bus.bids       = bids;
  assign bus.bids_valid = bids_valid;
  assign bus.bids_sat   = bids_sat;
  assign bus.err_class  = err_class;
endmodule
